mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum ACCESS cycles without mem_ack_i before abort (range 1..255).
REQ-002 SHALL have port clk_i  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port valid_i  input  1  an EX-stage instruction is presented.
REQ-005 SHALL have port RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i  input  1 each  EX-stage control bits.
REQ-006 SHALL have port ALUResult_i  input  32  ALU result; this is the memory address for loads and stores.
REQ-007 SHALL have port MemWdata_i  input  32  store data.
REQ-008 SHALL have port rd_i  input  5  destination register.
REQ-009 SHALL have port mem_req_o  output  1  data-memory request.
REQ-010 SHALL have port mem_we_o  output  1  1 = write.
REQ-011 SHALL have port mem_addr_o, mem_wdata_o  output  32 each  memory address and write data.
REQ-012 SHALL have port mem_ack_i  input  1  memory completion.
REQ-013 SHALL have port mem_rdata_i  input  32  read data, valid when mem_ack_i=1.
REQ-014 SHALL have port RegWrite_o, MemtoReg_o  output  1 each  control bits to the MEM/WB register.
REQ-015 SHALL have port data_o, Readdata_o  output  32 each  ALU result and load data to the MEM/WB register.
REQ-016 SHALL have port rd_o  output  5  destination register to the MEM/WB register.
REQ-017 SHALL have port stall_o  output  1  freeze the upstream pipeline.
REQ-018 SHALL have port err_o  output  1  one-cycle pulse signalling a misaligned access or a timeout.

Function
REQ-019 SHALL implement a 3-state FSM with states IDLE, ACCESS and RESP.
REQ-020 SHALL, at each posedge while stall_o=0, capture all EX inputs into an internal latch; valid_i=0 captures a bubble with all control bits 0.
- Non-memory ops appear on the outputs 1 cycle after capture.
REQ-021 SHALL select the next state at capture as follows:
- aligned memory op (MemRead_i or MemWrite_i, ALUResult_i[1:0]=00) -> ACCESS;
- anything else -> IDLE.
REQ-022 SHALL treat a misaligned memory op as follows:
- clear the latched RegWrite, MemRead and MemWrite;
- issue no memory request;
- pulse err_o for the following cycle.
REQ-023 SHALL make stall_o=1 exactly while state=ACCESS, and hold the latch contents during that time.
REQ-024 SHALL, in ACCESS, drive mem_req_o=1 with mem_we_o, mem_addr_o and mem_wdata_o from the latch; these SHALL stay stable until ack or abort.
REQ-025 SHALL drive mem_req_o=0 outside ACCESS, and ignore mem_ack_i outside ACCESS.
REQ-026 SHALL, while in ACCESS, force RegWrite_o=0 and MemtoReg_o=0 so that the unconditionally-sampling MEM/WB register receives bubbles.
REQ-027 SHALL, on a posedge with mem_ack_i=1 in ACCESS:
- register mem_rdata_i into Readdata_o (loads only; stores leave it unchanged);
- go to RESP.
- Minimum memory-op occupancy is therefore 2 cycles: 1 ACCESS cycle plus 1 RESP cycle.
REQ-028 SHALL, in RESP, present the latched RegWrite, MemtoReg, ALU result and rd, with stall_o=0; the next instruction is captured at the end of RESP.
REQ-029 SHALL use an 8-bit wait counter:
- cleared on entry to ACCESS;
- incremented each ACCESS cycle without ack;
- on reaching TIMEOUT without ack: go to IDLE, clear the latched RegWrite/MemtoReg, pulse err_o, drop mem_req_o.
REQ-030 SHALL give precedence to ack when ack and timeout occur in the same cycle.
REQ-031 SHALL register err_o and hold it high for exactly one cycle per event.
REQ-032 SHALL drive data_o from the latched ALU result and rd_o from the latched rd in every state.

Reset
REQ-033 SHALL, while rst_i=0 and independently of the clock:
- state=IDLE, latch cleared, counter=0;
- all outputs 0 (mem_req_o, stall_o, err_o, RegWrite_o, MemtoReg_o, data_o, Readdata_o, rd_o, mem_we_o, mem_addr_o, mem_wdata_o).
REQ-034 SHALL, on reset assertion during ACCESS, abandon the access with no err_o pulse; a late mem_ack_i after release SHALL be ignored.

Verification
REQ-035 SHALL cover non-memory op: valid_i=1, RegWrite_i=1, ALUResult_i=0x0000_1234, rd_i=5 -> next cycle RegWrite_o=1, data_o=0x1234, rd_o=5, stall_o=0.
REQ-036 SHALL cover a load with ack after 3 cycles: MemRead_i=1, MemtoReg_i=1, addr 0x100, mem_rdata_i=0xDEAD_BEEF -> mem_req_o high for 3 cycles, stall_o high for 3 cycles, RegWrite_o=0 during ACCESS; then RESP shows Readdata_o=0xDEADBEEF, RegWrite_o=1, MemtoReg_o=1.
REQ-037 SHALL cover a store with same-cycle ack: MemWrite_i=1, addr 0x8, MemWdata_i=0x55 -> 1 ACCESS cycle with mem_we_o=1, mem_addr_o=0x8, mem_wdata_o=0x55; no RegWrite_o.
REQ-038 SHALL cover misaligned: MemRead_i=1, addr 0x102 -> no mem_req_o, err_o=1 for 1 cycle, RegWrite_o=0.
REQ-039 SHALL cover timeout: TIMEOUT=4 with mem_ack_i held 0 -> mem_req_o high for 4 cycles, then err_o pulse, state IDLE, stall_o=0.
REQ-040 SHALL cover reset mid-ACCESS: rst_i=0 on the 2nd ACCESS cycle -> all outputs 0 immediately; mem_ack_i=1 after release has no effect.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-access stage between EX and MEM/WB. Latches each EX instruction,
// runs aligned loads/stores against a handshaking data memory, stalls the
// upstream pipeline while waiting, and aborts with an error pulse on a
// misaligned address or when the memory never acknowledges.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | latch holds a non-memory op, bubble or aborted op; capture on
//          | every edge
//   ACCESS | memory request outstanding; pipeline frozen, latch held
//   RESP   | memory op completed; latched results presented for one cycle

module mem_access_unit #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        valid_i,
   input  logic        RegWrite_i,
   input  logic        MemtoReg_i,
   input  logic        MemRead_i,
   input  logic        MemWrite_i,
   input  logic [31:0] ALUResult_i,
   input  logic [31:0] MemWdata_i,
   input  logic [4:0]  rd_i,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_rdata_i,
   output logic        RegWrite_o,
   output logic        MemtoReg_o,
   output logic [31:0] data_o,
   output logic [31:0] Readdata_o,
   output logic [4:0]  rd_o,
   output logic        stall_o,
   output logic        err_o
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   // Abort fires on the ACCESS cycle whose wait count is TIMEOUT-1, so the
   // request is held for exactly TIMEOUT cycles.
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        rw_q, rw_d;
   logic        mtr_q, mtr_d;
   logic        mr_q, mr_d;
   logic        mw_q, mw_d;
   logic [31:0] alu_q, alu_d;
   logic [31:0] wd_q, wd_d;
   logic [4:0]  rd_q, rd_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic        mem_op;
   logic        misaligned;
   logic        in_access;

   // Next-state and latch update: capture in IDLE/RESP, wait/ack/abort in ACCESS.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rw_d       = rw_q;
      mtr_d      = mtr_q;
      mr_d       = mr_q;
      mw_d       = mw_q;
      alu_d      = alu_q;
      wd_d       = wd_q;
      rd_d       = rd_q;
      rdata_d    = rdata_q;
      err_d      = 1'b0;
      mem_op     = valid_i & (MemRead_i | MemWrite_i);
      misaligned = mem_op & (ALUResult_i[1:0] != 2'b00);
      case (state_q)
         IDLE, RESP: begin
            // A misaligned op keeps MemtoReg but can neither write back nor touch memory.
            rw_d    = valid_i & RegWrite_i & ~misaligned;
            mtr_d   = valid_i & MemtoReg_i;
            mr_d    = valid_i & MemRead_i & ~misaligned;
            mw_d    = valid_i & MemWrite_i & ~misaligned;
            alu_d   = ALUResult_i;
            wd_d    = MemWdata_i;
            rd_d    = rd_i;
            err_d   = misaligned;
            cnt_d   = 8'd0;
            state_d = (mem_op & ~misaligned) ? ACCESS : IDLE;
         end
         ACCESS: begin
            // Ack wins over a coincident timeout.
            if (mem_ack_i) begin
               if (mr_q) rdata_d = mem_rdata_i;
               state_d = RESP;
            end else if (cnt_q == TO_LAST) begin
               rw_d    = 1'b0;
               mtr_d   = 1'b0;
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, latch, load data and error flops; reset abandons any access silently.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
         rw_q    <= 1'b0;
         mtr_q   <= 1'b0;
         mr_q    <= 1'b0;
         mw_q    <= 1'b0;
         alu_q   <= 32'd0;
         wd_q    <= 32'd0;
         rd_q    <= 5'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rw_q    <= rw_d;
         mtr_q   <= mtr_d;
         mr_q    <= mr_d;
         mw_q    <= mw_d;
         alu_q   <= alu_d;
         wd_q    <= wd_d;
         rd_q    <= rd_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Outputs are decoded only from flops; write-back controls read as a bubble during ACCESS.
   assign in_access   = (state_q == ACCESS);
   assign stall_o     = in_access;
   assign mem_req_o   = in_access;
   assign mem_we_o    = in_access & mw_q;
   assign mem_addr_o  = alu_q;
   assign mem_wdata_o = wd_q;
   assign RegWrite_o  = rw_q & ~in_access;
   assign MemtoReg_o  = mtr_q & ~in_access;
   assign data_o      = alu_q;
   assign rd_o        = rd_q;
   assign Readdata_o  = rdata_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios followed by random
// instructions with random memory latency, checked against a
// per-instruction expectation of the cycle sequence each op produces.

module tb_mem_access_unit;

   localparam int TO = 4;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        valid_i, RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i;
   logic [31:0] ALUResult_i, MemWdata_i;
   logic [4:0]  rd_i;
   logic        mem_req_o, mem_we_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic        mem_ack_i;
   logic [31:0] mem_rdata_i;
   logic        RegWrite_o, MemtoReg_o;
   logic [31:0] data_o, Readdata_o;
   logic [4:0]  rd_o;
   logic        stall_o, err_o;

   int          tests = 0;
   int          fails = 0;
   logic [31:0] exp_rdata = 32'd0;

   mem_access_unit #(.TIMEOUT(TO)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i),
      .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i),
      .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
      .ALUResult_i(ALUResult_i), .MemWdata_i(MemWdata_i), .rd_i(rd_i),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
      .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o),
      .data_o(data_o), .Readdata_o(Readdata_o), .rd_o(rd_o),
      .stall_o(stall_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input string fld, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
      end
   endtask

   // Checks the outputs every non-ACCESS cycle must show.
   task automatic chk_idle(input string tag, input logic e_err, input logic e_rw, input logic e_mtr,
                           input logic [31:0] e_data, input logic [4:0] e_rd);
      chk(tag, "stall_req", 64'({stall_o, mem_req_o}), 64'd0);
      chk(tag, "err", 64'(err_o), 64'(e_err));
      chk(tag, "rw_mtr", 64'({RegWrite_o, MemtoReg_o}), 64'({e_rw, e_mtr}));
      chk(tag, "data_rd", 64'({data_o, rd_o}), 64'({e_data, e_rd}));
      chk(tag, "readdata", 64'(Readdata_o), 64'(exp_rdata));
   endtask

   task automatic drive_junk();
      valid_i     = 1'($urandom);
      RegWrite_i  = 1'($urandom);
      MemtoReg_i  = 1'($urandom);
      MemRead_i   = 1'($urandom);
      MemWrite_i  = 1'($urandom);
      ALUResult_i = $urandom;
      MemWdata_i  = $urandom;
      rd_i        = 5'($urandom);
   endtask

   // Called at a negedge with the DUT able to capture; returns at the negedge
   // where the next instruction may be driven.
   task automatic run_instr(input string tag, input logic v, input logic rw, input logic mtr,
                            input logic mr, input logic mw, input logic [31:0] alu,
                            input logic [31:0] wd, input logic [4:0] rd, input int lat,
                            input logic [31:0] rv);
      logic memop, mis, done;
      valid_i = v; RegWrite_i = rw; MemtoReg_i = mtr; MemRead_i = mr; MemWrite_i = mw;
      ALUResult_i = alu; MemWdata_i = wd; rd_i = rd;
      mem_ack_i   = 1'($urandom);   // acks outside ACCESS must be ignored
      mem_rdata_i = $urandom;
      memop = v && (mr || mw);
      mis   = memop && (alu[1:0] != 2'b00);
      @(posedge clk_i); @(negedge clk_i);
      if (!memop || mis) begin
         chk_idle(tag, mis, v && rw && !mis, v && mtr, alu, rd);
      end else begin
         done = 1'b0;
         for (int k = 1; k <= TO && !done; k++) begin
            chk(tag, "acc_stall_req", 64'({stall_o, mem_req_o}), 64'(2'b11));
            chk(tag, "acc_rw_mtr_err", 64'({RegWrite_o, MemtoReg_o, err_o}), 64'd0);
            chk(tag, "acc_we_addr", 64'({mem_we_o, mem_addr_o}), 64'({mw, alu}));
            chk(tag, "acc_wdata_rd", 64'({mem_wdata_o, rd_o}), 64'({wd, rd}));
            drive_junk();
            mem_ack_i   = (k == lat);
            mem_rdata_i = (k == lat) ? rv : $urandom;
            @(posedge clk_i); @(negedge clk_i);
            if (k == lat) begin
               if (mr) exp_rdata = rv;
               chk_idle({tag, "_resp"}, 1'b0, rw, mtr, alu, rd);
               done = 1'b1;
            end else if (k == TO) begin
               chk_idle({tag, "_tmo"}, 1'b1, 1'b0, 1'b0, alu, rd);
               done = 1'b1;
            end
         end
      end
   endtask

   initial begin
      rst_i = 1'b0;
      valid_i = 0; RegWrite_i = 0; MemtoReg_i = 0; MemRead_i = 0; MemWrite_i = 0;
      ALUResult_i = 0; MemWdata_i = 0; rd_i = 0; mem_ack_i = 0; mem_rdata_i = 0;
      #2;
      chk("reset", "ctl", 64'({mem_req_o, stall_o, err_o, RegWrite_o, MemtoReg_o, mem_we_o, rd_o}), 64'd0);
      chk("reset", "data_rdata", 64'({data_o, Readdata_o}), 64'd0);
      chk("reset", "addr_wdata", 64'({mem_addr_o, mem_wdata_o}), 64'd0);
      @(negedge clk_i); @(negedge clk_i);
      rst_i = 1'b1;

      run_instr("nonmem", 1, 1, 0, 0, 0, 32'h0000_1234, 32'h0, 5'd5, 1, 32'h0);
      run_instr("load3", 1, 1, 1, 1, 0, 32'h0000_0100, 32'h0, 5'd7, 3, 32'hDEAD_BEEF);
      run_instr("store1", 1, 0, 0, 0, 1, 32'h0000_0008, 32'h55, 5'd0, 1, 32'h1111_2222);
      run_instr("misalign", 1, 1, 0, 1, 0, 32'h0000_0102, 32'h0, 5'd9, 1, 32'h0);
      run_instr("after_mis", 1, 0, 0, 0, 0, 32'h0000_0ABC, 32'h0, 5'd3, 1, 32'h0);
      run_instr("timeout", 1, 1, 1, 1, 0, 32'h0000_0200, 32'h0, 5'd4, 99, 32'h0);
      run_instr("bubble", 0, 1, 1, 1, 1, 32'h0000_0300, 32'h0, 5'd6, 1, 32'h0);

      // Reset on the second ACCESS cycle of a load, then a late ack.
      valid_i = 1; RegWrite_i = 1; MemtoReg_i = 1; MemRead_i = 1; MemWrite_i = 0;
      ALUResult_i = 32'h0000_0400; MemWdata_i = 0; rd_i = 5'd8; mem_ack_i = 0;
      @(posedge clk_i); @(negedge clk_i);
      chk("rst_mid", "acc1_req", 64'({mem_req_o, stall_o}), 64'(2'b11));
      @(posedge clk_i); @(negedge clk_i);
      rst_i = 1'b0;
      #1;
      chk("rst_mid", "ctl", 64'({mem_req_o, stall_o, err_o, RegWrite_o, MemtoReg_o, mem_we_o, rd_o}), 64'd0);
      chk("rst_mid", "data_rdata", 64'({data_o, Readdata_o}), 64'd0);
      chk("rst_mid", "addr_wdata", 64'({mem_addr_o, mem_wdata_o}), 64'd0);
      exp_rdata = 32'd0;
      @(negedge clk_i);
      rst_i = 1'b1; valid_i = 0; mem_ack_i = 1; mem_rdata_i = 32'hCAFE_F00D;
      @(posedge clk_i); @(negedge clk_i);
      chk_idle("late_ack", 1'b0, 1'b0, 1'b0, 32'h0000_0400, 5'd8);
      mem_ack_i = 0;

      for (int n = 0; n < 300; n++) begin
         int          op;
         logic [31:0] a;
         op = int'($urandom_range(0, 2));
         a  = $urandom;
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         run_instr("rand", ($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom),
                   (op == 1), (op == 2), a, $urandom, 5'($urandom),
                   int'($urandom_range(1, 6)), $urandom);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
